// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the four-way traffic-light controller.
//   - Lamp codes {red, yellow, green}, one-hot.
//   - FSM state enum (the ALL_RED clearance state exists only when
//     TRAFFIC_ALL_RED_EN is defined).
//   - Approach enum and a helper mapping an approach to its green state.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

`ifdef TRAFFIC_ALL_RED_EN
    typedef enum logic [3:0] {
        N_G, N_Y, S_G, S_Y, E_G, E_Y, W_G, W_Y, ALL_RED
    } state_t;
`else
    typedef enum logic [3:0] {
        N_G, N_Y, S_G, S_Y, E_G, E_Y, W_G, W_Y
    } state_t;
`endif

    typedef enum logic [1:0] {
        NORTH, SOUTH, EAST, WEST
    } approach_t;

    function automatic state_t green_state(approach_t a);
        unique case (a)
            NORTH:   return N_G;
            SOUTH:   return S_G;
            EAST:    return E_G;
            default: return W_G;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: phase counter that restarts at 0 on each state entry.
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset, clears the count
//   restart  : clears the count at the next edge (asserted on state change)
//   duration : last count value of the current phase (phase length - 1)
//   done     : high during the final cycle of the phase
module traffic_phase_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             restart,
    input  logic [WIDTH-1:0] duration,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == duration);

endmodule

// File: rtl/traffic.sv
// traffic: four-way round-robin traffic-light controller (N, S, E, W).
//   north/south/east/west : 3-bit lamp codes {red, yellow, green}
//   clock                 : rising-edge clock
//   reset                 : synchronous active-high reset (forces north green)
// Optional feature macro: TRAFFIC_ALL_RED_EN adds an all-red clearance phase
// of ALL_RED_CYCLES after every yellow.
module traffic
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES   = 8,
    parameter int unsigned YELLOW_CYCLES  = 3,
    parameter int unsigned ALL_RED_CYCLES = 2
) (
    output logic [2:0] north,
    output logic [2:0] south,
    output logic [2:0] east,
    output logic [2:0] west,
    input  logic       clock,
    input  logic       reset
);

    localparam int unsigned MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES
                                                                     : YELLOW_CYCLES;
    localparam int unsigned MAX_DUR = (MAX_GY > ALL_RED_CYCLES) ? MAX_GY : ALL_RED_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_DUR) > 0) ? $clog2(MAX_DUR) : 1;

    localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYCLES - 1);
`ifdef TRAFFIC_ALL_RED_EN
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED_CYCLES - 1);
`endif

    state_t           state;
    logic             phase_done;
    logic [CNT_W-1:0] duration;

    // Timer restarts whenever the FSM leaves its state, so count is 0 on entry.
    traffic_phase_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (phase_done),
        .duration (duration),
        .done     (phase_done)
    );

    always_comb begin
        duration = G_LAST;
        unique case (state)
            N_Y, S_Y, E_Y, W_Y: duration = Y_LAST;
`ifdef TRAFFIC_ALL_RED_EN
            ALL_RED:            duration = AR_LAST;
`endif
            default:            duration = G_LAST;
        endcase
    end

`ifdef TRAFFIC_ALL_RED_EN
    approach_t next_app;

    // Every yellow passes through one shared clearance state; next_app
    // remembers which approach gets green afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= N_G;
            next_app <= NORTH;
        end else if (phase_done) begin
            unique case (state)
                N_G:     state <= N_Y;
                N_Y:     begin state <= ALL_RED; next_app <= SOUTH; end
                S_G:     state <= S_Y;
                S_Y:     begin state <= ALL_RED; next_app <= EAST;  end
                E_G:     state <= E_Y;
                E_Y:     begin state <= ALL_RED; next_app <= WEST;  end
                W_G:     state <= W_Y;
                W_Y:     begin state <= ALL_RED; next_app <= NORTH; end
                ALL_RED: state <= green_state(next_app);
                default: state <= N_G;
            endcase
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= N_G;
        end else if (phase_done) begin
            unique case (state)
                N_G:     state <= N_Y;
                N_Y:     state <= S_G;
                S_G:     state <= S_Y;
                S_Y:     state <= E_G;
                E_G:     state <= E_Y;
                E_Y:     state <= W_G;
                W_G:     state <= W_Y;
                W_Y:     state <= N_G;
                default: state <= N_G;
            endcase
        end
    end
`endif

    always_comb begin
        north = LIGHT_RED;
        south = LIGHT_RED;
        east  = LIGHT_RED;
        west  = LIGHT_RED;
        unique case (state)
            N_G:     north = LIGHT_GREEN;
            N_Y:     north = LIGHT_YELLOW;
            S_G:     south = LIGHT_GREEN;
            S_Y:     south = LIGHT_YELLOW;
            E_G:     east  = LIGHT_GREEN;
            E_Y:     east  = LIGHT_YELLOW;
            W_G:     west  = LIGHT_GREEN;
            W_Y:     west  = LIGHT_YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic.sv
// tb_traffic: scoreboard bench for traffic. Two instances run side by side:
// one with default timing, one with GREEN_CYCLES=YELLOW_CYCLES=1. Expected
// lamp words {north, south, east, west} come from a cycle-index model.
module tb_traffic;

    logic       clock;
    logic       reset;
    logic [2:0] n0, s0, e0, w0;
    logic [2:0] n1, s1, e1, w1;

    int unsigned total;
    int unsigned bad;
    int unsigned cyc;

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];

`ifdef TRAFFIC_ALL_RED_EN
    localparam int unsigned AR0 = 2;
    localparam int unsigned AR1 = 1;
`else
    localparam int unsigned AR0 = 0;
    localparam int unsigned AR1 = 0;
`endif
    localparam int unsigned G0 = 8;
    localparam int unsigned Y0 = 3;
    localparam int unsigned L0 = G0 + Y0 + AR0;

    traffic dut0 (
        .north (n0),
        .south (s0),
        .east  (e0),
        .west  (w0),
        .clock (clock),
        .reset (reset)
    );

    traffic #(
        .GREEN_CYCLES   (1),
        .YELLOW_CYCLES  (1),
        .ALL_RED_CYCLES (1)
    ) dut1 (
        .north (n1),
        .south (s1),
        .east  (e1),
        .west  (w1),
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    // Expected lamps for cycle n: each approach owns a slot of length g+y+ar.
    function automatic logic [11:0] model(int unsigned n, int unsigned g, int unsigned y,
                                          int unsigned ar);
        int unsigned len = g + y + ar;
        int unsigned t   = n % (4 * len);
        int unsigned a   = t / len;
        int unsigned r   = t % len;
        logic [2:0]  lamp;
        logic [11:0] word;
        if (r < g)          lamp = 3'b001;
        else if (r < g + y) lamp = 3'b010;
        else                lamp = 3'b100;
        word = {4{3'b100}};
        word[11 - 3*a -: 3] = lamp;
        return word;
    endfunction

    function automatic logic legal(logic [2:0] l);
        return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
    endfunction

    function automatic int unsigned non_red(logic [11:0] w);
        int unsigned c = 0;
        for (int i = 0; i < 4; i++) if (w[3*i +: 3] != 3'b100) c++;
        return c;
    endfunction

    task automatic push_exp(input int unsigned n);
        exp_q0.push_back(model(n, G0, Y0, AR0));
        exp_q1.push_back(model(n, 1, 1, AR1));
    endtask

    task automatic pop_check();
        logic [11:0] got0;
        logic [11:0] got1;
        got0 = {n0, s0, e0, w0};
        got1 = {n1, s1, e1, w1};
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            check_val("sb_empty", 32'(exp_q0.size() * exp_q1.size()), 32'd1);
        end else begin
            check_val("lamps_def", 32'(got0), 32'(exp_q0.pop_front()));
            check_val("lamps_g1y1", 32'(got1), 32'(exp_q1.pop_front()));
        end
        check_val("legal_def", 32'(legal(n0) & legal(s0) & legal(e0) & legal(w0)), 32'd1);
        check_val("legal_g1y1", 32'(legal(n1) & legal(s1) & legal(e1) & legal(w1)), 32'd1);
        check_val("one_live_def", 32'(non_red(got0) <= 1), 32'd1);
        check_val("one_live_g1y1", 32'(non_red(got1) <= 1), 32'd1);
    endtask

    // Advance one cycle: queue expectation for the coming cycle, then check it.
    task automatic step();
        push_exp(cyc + 1);
        @(negedge clock);
        cyc++;
        pop_check();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b1;
        // Two reset edges; outputs must already show the reset pattern.
        repeat (2) begin
            push_exp(0);
            @(posedge clock);
            @(negedge clock);
            pop_check();
        end
        reset = 1'b0;

        // Two full rotations plus margin, then stop in east yellow.
        repeat (4 * L0 * 2 + 10) step();
        while ((cyc % (4 * L0)) != (2 * L0 + G0 + 1)) step();
        check_val("east_yellow", 32'(e0), 32'h2);

        // One-cycle reset mid-phase restarts at north green, count 0.
        reset = 1'b1;
        push_exp(0);
        @(negedge clock);
        cyc = 0;
        pop_check();
        reset = 1'b0;

        repeat (500) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
